// File: rtl/io_arb_pkg.sv
// Shared types and constants for the two-master IO bus arbiter.
package io_arb_pkg;

  localparam int unsigned DW      = 16;
  localparam int unsigned AW      = 13;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/io_arb_rr.sv
// Combinational winner select between the two masters.
// IO_ARB_FIXED_PRIO_EN makes m0 win every tie; otherwise ties alternate.
module io_arb_rr
  import io_arb_pkg::*;
(
  input  logic m0_req,
  input  logic m1_req,
  input  logic last_grant,
  output logic grant_c
);

`ifdef IO_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_c = M0;
    if (m1_req && !m0_req) grant_c = M1;
  end
`else
  always_comb begin
    grant_c = M0;
    if (m0_req && m1_req) grant_c = ~last_grant;
    else if (m1_req)      grant_c = M1;
  end
`endif

endmodule

// File: rtl/io_arb.sv
// Two-master arbiter and 4-cycle access sequencer for the IO peripheral bus.
// Optional IO_ARB_FIXED_PRIO_EN (see io_arb_rr) selects fixed m0 priority.
module io_arb
  import io_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] io_addr,
  output logic [DW-1:0] io_din,
  output logic          io_we,
  input  logic [DW-1:0] io_dout,
  output logic          busy
);

  state_t        state, state_d;
  logic          last_grant, last_grant_d;
  logic          win_id, win_id_d;
  logic          win_we, win_we_d;
  logic [AW-1:0] io_addr_d;
  logic [DW-1:0] io_din_d;
  logic          io_we_d;
  logic          m0_ack_d, m1_ack_d;
  logic [DW-1:0] m0_rdata_d, m1_rdata_d;
  logic          busy_d;
  logic          grant_c;

  io_arb_rr u_rr (
    .m0_req     (m0_req),
    .m1_req     (m1_req),
    .last_grant (last_grant),
    .grant_c    (grant_c)
  );

  // State and every output are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= M1;
      win_id     <= M0;
      win_we     <= 1'b0;
      io_addr    <= '0;
      io_din     <= '0;
      io_we      <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      win_id     <= win_id_d;
      win_we     <= win_we_d;
      io_addr    <= io_addr_d;
      io_din     <= io_din_d;
      io_we      <= io_we_d;
      m0_ack     <= m0_ack_d;
      m1_ack     <= m1_ack_d;
      m0_rdata   <= m0_rdata_d;
      m1_rdata   <= m1_rdata_d;
      busy       <= busy_d;
    end
  end

  // Next-state and next-output logic; masters are sampled only in IDLE.
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    win_id_d     = win_id;
    win_we_d     = win_we;
    io_addr_d    = io_addr;
    io_din_d     = io_din;
    io_we_d      = 1'b0;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata;
    m1_rdata_d   = m1_rdata;

    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d      = ISSUE;
          win_id_d     = grant_c;
          last_grant_d = grant_c;
          if (grant_c == M0) begin
            win_we_d  = m0_we;
            io_we_d   = m0_we;
            io_addr_d = m0_addr;
            io_din_d  = m0_wdata;
          end else begin
            win_we_d  = m1_we;
            io_we_d   = m1_we;
            io_addr_d = m1_addr;
            io_din_d  = m1_wdata;
          end
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        state_d = DONE;
        // io_dout carries the read result during this cycle.
        if (win_id == M0) begin
          m0_ack_d = 1'b1;
          if (!win_we) m0_rdata_d = io_dout;
        end else begin
          m1_ack_d = 1'b1;
          if (!win_we) m1_rdata_d = io_dout;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_io_arb.sv
// Directed self-checking bench for io_arb.
module tb_io_arb;
  import io_arb_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] io_din;
  logic          io_we;
  logic [DW-1:0] io_dout;
  logic          busy;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  io_arb dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .io_addr  (io_addr),
    .io_din   (io_din),
    .io_we    (io_we),
    .io_dout  (io_dout),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    io_dout = 16'hFFFF;
    tick(); tick();
    chk("rst_io_addr", 32'(io_addr), 32'h0);
    chk("rst_io_din", 32'(io_din), 32'h0);
    chk("rst_io_we", 32'(io_we), 32'h0);
    chk("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
    chk("rst_m0_rdata", 32'(m0_rdata), 32'h0);
    chk("rst_m1_rdata", 32'(m1_rdata), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();

    // m0 write 0x01 <- 0xA5A5
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 13'h01; m0_wdata = 16'hA5A5;
    tick();
    chk("wr_issue_we", 32'(io_we), 32'h1);
    chk("wr_issue_addr", 32'(io_addr), 32'h01);
    chk("wr_issue_din", 32'(io_din), 32'hA5A5);
    chk("wr_issue_busy", 32'(busy), 32'h1);
    chk("wr_issue_ack", 32'(m0_ack), 32'h0);
    tick();
    chk("wr_resp_we", 32'(io_we), 32'h0);
    chk("wr_resp_ack", 32'(m0_ack), 32'h0);
    tick();
    chk("wr_done_m0_ack", 32'(m0_ack), 32'h1);
    chk("wr_done_m1_ack", 32'(m1_ack), 32'h0);
    m0_req = 1'b0;
    tick();
    chk("wr_idle_ack", 32'(m0_ack), 32'h0);
    chk("wr_idle_busy", 32'(busy), 32'h0);

    // m1 read 0x00, IO returns 0x1234
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 13'h00;
    tick();
    chk("rd_issue_we", 32'(io_we), 32'h0);
    chk("rd_issue_addr", 32'(io_addr), 32'h00);
    io_dout = 16'h1234;
    tick();
    chk("rd_resp_we", 32'(io_we), 32'h0);
    tick();
    chk("rd_done_m1_ack", 32'(m1_ack), 32'h1);
    chk("rd_done_m1_rdata", 32'(m1_rdata), 32'h1234);
    chk("rd_done_m0_rdata", 32'(m0_rdata), 32'h0);
    chk("rd_done_m0_ack", 32'(m0_ack), 32'h0);
    m1_req = 1'b0;
    io_dout = 16'hFFFF;
    tick();
    chk("rd_rdata_held", 32'(m1_rdata), 32'h1234);

    // stale request: m0 read held into DONE, dropped after ack
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 13'h05;
    tick();
    io_dout = 16'h0BEE;
    tick(); tick();
    chk("stale_ack", 32'(m0_ack), 32'h1);
    chk("stale_rdata", 32'(m0_rdata), 32'h0BEE);
    m0_req = 1'b0;
    io_dout = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stale_no_busy", 32'(busy), 32'h0);
      chk("stale_no_ack", 32'(m0_ack), 32'h0);
    end
    chk("stale_rdata_kept", 32'(m0_rdata), 32'h0BEE);

    // latched operands: m1 changes address during ISSUE
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 13'h00;
    tick();
    chk("latch_issue_addr", 32'(io_addr), 32'h00);
    m1_addr = 13'h01;
    tick();
    chk("latch_resp_addr", 32'(io_addr), 32'h00);
    tick();
    chk("latch_done_addr", 32'(io_addr), 32'h00);
    chk("latch_done_ack", 32'(m1_ack), 32'h1);
    m1_req = 1'b0;
    tick();
    chk("latch_idle_addr", 32'(io_addr), 32'h00);

    // reset asserted during ISSUE of an m0 write
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 13'h07; m0_wdata = 16'h5A5A;
    tick();
    chk("rmid_issue_we", 32'(io_we), 32'h1);
    rst = 1'b1;
    #1;
    chk("rmid_we", 32'(io_we), 32'h0);
    chk("rmid_busy", 32'(busy), 32'h0);
    chk("rmid_ack", 32'(m0_ack), 32'h0);
    chk("rmid_addr", 32'(io_addr), 32'h0);
    m0_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rmid_post_ack", 32'(m0_ack), 32'h0);
      chk("rmid_post_we", 32'(io_we), 32'h0);
    end
    m0_req = 1'b1;
    tick();
    chk("rmid_fresh_we", 32'(io_we), 32'h1);
    chk("rmid_fresh_addr", 32'(io_addr), 32'h07);
    chk("rmid_fresh_din", 32'(io_din), 32'h5A5A);
    tick(); tick();
    chk("rmid_fresh_ack", 32'(m0_ack), 32'h1);
    m0_req = 1'b0;
    tick();

    // ties after reset: m0 reads 0x02, m1 reads 0x03, both held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 13'h02;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 13'h03;
    for (int i = 0; i < 4; i++) begin
      logic exp_m1;
`ifdef IO_ARB_FIXED_PRIO_EN
      exp_m1 = 1'b0;
`else
      exp_m1 = (i % 2) == 1;
`endif
      tick();
      chk("tie_issue_addr", 32'(io_addr), exp_m1 ? 32'h03 : 32'h02);
      tick(); tick();
      chk("tie_m0_ack", 32'(m0_ack), exp_m1 ? 32'h0 : 32'h1);
      chk("tie_m1_ack", 32'(m1_ack), exp_m1 ? 32'h1 : 32'h0);
      tick();
      chk("tie_gap_acks", 32'({m0_ack, m1_ack}), 32'h0);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/io_arb.md
# io_arb

Two-master arbiter and access sequencer for the memory-mapped IO peripheral bus (`din`/`addr`/`we`/`dout`). It sits between the processor core (master 0) and an auxiliary requester such as a debug or loader port (master 1), and the IO block (GPIO in/out registers). It serialises requests, drives exactly one bus access at a time, and returns read data with a one-cycle acknowledge pulse. It hides the IO block's one-cycle registered read latency from both masters.

## Interface
- `DW`, 16, data width; matches the IO block.
- `AW`, 13, address width; matches the IO block.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `m0_req` input 1: master 0 request; hold until `m0_ack`.
- `m0_we` input 1: master 0 write (1) / read (0).
- `m0_addr` input AW: master 0 address.
- `m0_wdata` input DW: master 0 write data.
- `m0_ack` output 1: one-cycle completion pulse.
- `m0_rdata` output DW: read data, valid with `m0_ack` and held until the next m0 read.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ack`, `m1_rdata`: same meanings for master 1.
- `io_addr` output AW: to IO `addr`.
- `io_din` output DW: to IO `din`.
- `io_we` output 1: to IO `we`.
- `io_dout` input DW: from IO `dout`; valid the cycle after a read is issued.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE -> ISSUE when any req is high; otherwise stay in IDLE.
  - ISSUE -> RESP unconditionally.
  - RESP -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- Entering ISSUE:
  - Latch the winner id and the winner's we/addr/wdata into registers that drive `io_*`.
  - Master signals are not sampled again until IDLE.
- ISSUE: `io_we` = latched we. `io_addr`/`io_din` driven from the latch. The IO block acts at the edge ending ISSUE.
- RESP: `io_dout` is valid. At the edge ending RESP:
  - For a read, the winner's `mX_rdata` <= `io_dout`.
  - The winner's `mX_ack` <= 1.
- DONE:
  - `mX_ack` is high for exactly this cycle.
  - The master drops or changes req at the edge ending DONE.
  - Requests are not evaluated in DONE, so a stale req is never re-granted.
- Outside ISSUE:
  - `io_we` = 0.
  - `io_addr` holds its last value (0 after reset).
- Arbitration, evaluated only in IDLE:
  - Single requester wins.
  - On a tie, the master not granted last wins (round robin).
  - `last_grant` resets to 1, so m0 wins the first tie.
- Writes leave `mX_rdata` unchanged.
- Reset values:
  - state = IDLE, `last_grant` = 1.
  - `io_addr`, `io_din`, `io_we` = 0.
  - `m0_ack`, `m1_ack` = 0.
  - `m0_rdata`, `m1_rdata` = 0.
  - `busy` = 0.
- Reset mid-access: all outputs are forced to reset values immediately (asynchronous). No ack is issued and no write is performed after the reset edge. The master re-requests.

## Timing
- Every access takes 4 cycles, from the IDLE cycle in which req is seen to the end of DONE. Maximum bus throughput is one access per 4 cycles.
- Latency: ack is asserted 3 cycles after the cycle req is first sampled in IDLE.
- A loser waits at most one full access (4 cycles) plus its own 4.
- `io_we` is high for exactly one cycle per write access and never for reads.
- All outputs are registered. There is no combinational path from `mX_*` or `io_dout` to any output.

## Configuration
- `IO_ARB_FIXED_PRIO_EN`:
  - Defined: m0 always wins ties and `last_grant` is unused. m1 can starve under continuous m0 traffic.
  - Undefined (default): round-robin as described above.

## Structure
- Package `io_arb_pkg`:
  - state encoding localparams (IDLE/ISSUE/RESP/DONE, 2 bits);
  - master id constants `M0`/`M1`.
- Sub-module `io_arb_rr`: combinational winner select from `m0_req`, `m1_req`, `last_grant`. It also contains the `IO_ARB_FIXED_PRIO_EN` switch.
- The FSM, latches and the read-return path live in `io_arb`.

## Test plan
- Write: m0 write, addr 0x01, data 0xA5A5.
  - `io_we` = 1 for exactly the ISSUE cycle, with `io_addr` = 0x01 and `io_din` = 0xA5A5.
  - `m0_ack` pulses 3 cycles after req.
  - `m1_ack` stays 0.
- Read: m1 read, addr 0x00, with `io_dout` = 0x1234 in RESP.
  - `m1_rdata` = 0x1234 with `m1_ack`.
  - `io_we` stays 0.
  - `m0_rdata` remains 0.
- Ties after reset: both reqs held high continuously. Grants alternate m0, m1, m0, m1, with acks 4 cycles apart. With `IO_ARB_FIXED_PRIO_EN`, m0 only.
- Reset during ISSUE of an m0 write: `io_we` drops to 0 immediately, no `m0_ack`, `busy` = 0. After release, a fresh req completes normally.
- Stale request: m0 holds req through DONE and deasserts after the ack. No second access is issued.
- Latched operands: m1 changes `m1_addr` 0x00 -> 0x01 during ISSUE. `io_addr` stays 0x00 for the whole access.
